// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: address/data types, FSM states,
// fault causes, RV32I funct3 codes and the request classifier.
package load_store_unit_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_RESP   = 2'b10
    } lsu_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_ILLEGAL  = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } fault_cause_t;

    localparam logic [2:0] LSU_F3__LB  = 3'b000;
    localparam logic [2:0] LSU_F3__LH  = 3'b001;
    localparam logic [2:0] LSU_F3__LW  = 3'b010;
    localparam logic [2:0] LSU_F3__LBU = 3'b100;
    localparam logic [2:0] LSU_F3__LHU = 3'b101;
    localparam logic [2:0] LSU_F3__SB  = 3'b000;
    localparam logic [2:0] LSU_F3__SH  = 3'b001;
    localparam logic [2:0] LSU_F3__SW  = 3'b010;

    // Illegal encodings win over misalignment because the width is meaningless then.
    function automatic fault_cause_t lsu_classify(input logic       is_write,
                                                  input logic [2:0] f3,
                                                  input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        if (is_write) begin
            legal = (f3 == LSU_F3__SB) || (f3 == LSU_F3__SH) || (f3 == LSU_F3__SW);
        end else begin
            legal = (f3 == LSU_F3__LB) || (f3 == LSU_F3__LH) || (f3 == LSU_F3__LW) ||
                    (f3 == LSU_F3__LBU) || (f3 == LSU_F3__LHU);
        end
        case (f3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (!legal) begin
            return FAULT_ILLEGAL;
        end
        if (misaligned) begin
            return FAULT_MISALIGN;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    addr_t       addr;
    data_t       wdata;
    logic        busy;
    logic        done;
    data_t       rdata;
    logic [1:0]  fault_cause;

    logic        mem_req;
    logic        mem_we;
    addr_t       mem_addr;
    data_t       mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    data_t       mem_rdata;

    modport slave (
        input  req_valid, req_write, funct3, addr, wdata, mem_ack, mem_rdata,
        output busy, done, rdata, fault_cause, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_write, funct3, addr, wdata, mem_ack, mem_rdata,
        input  busy, done, rdata, fault_cause, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: byte enables, store replication and
// load extraction with sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    input  data_t      wdata,
    input  data_t      mem_rdata,
    output logic [3:0] be,
    output data_t      mem_wdata,
    output data_t      load_data
);

    data_t              shifted;
    logic signed [7:0]  ld_b;
    logic signed [15:0] ld_h;

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                mem_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << addr_lo;
                mem_wdata = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                mem_wdata = wdata;
            end
        endcase
    end

    // funct3[2] selects zero extension (LBU/LHU); LW needs none.
    always_comb begin
        shifted = mem_rdata >> {addr_lo, 3'b000};
        ld_b    = shifted[7:0];
        ld_h    = shifted[15:0];
        case (funct3)
            LSU_F3__LB:  load_data = 32'(ld_b);
            LSU_F3__LH:  load_data = 32'(ld_h);
            LSU_F3__LBU: load_data = {24'd0, shifted[7:0]};
            LSU_F3__LHU: load_data = {16'd0, shifted[15:0]};
            default:     load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: latches one request, performs one
// word-aligned memory access with timeout, and reports a one-cycle completion.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    data_t            rdata_q, rdata_d;
    fault_cause_t     cause_q, cause_d;
    logic             write_q, write_d;
    logic [2:0]       f3_q, f3_d;
    addr_t            addr_q, addr_d;
    data_t            wdata_q, wdata_d;

    fault_cause_t     req_fault;
    logic             in_access;
    logic [3:0]       align_be;
    data_t            align_wdata;
    data_t            align_load;

    lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .mem_rdata (bus.mem_rdata),
        .be        (align_be),
        .mem_wdata (align_wdata),
        .load_data (align_load)
    );

    assign req_fault = lsu_classify(bus.req_write, bus.funct3, bus.addr[1:0]);

    // Result registers change only on the edge entering RESP, so
    // fault_cause and rdata hold steady between done pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        cause_d = cause_q;
        write_d = write_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    f3_d    = bus.funct3;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = '0;
                    if (req_fault != FAULT_NONE) begin
                        state_d = LSU_RESP;
                        cause_d = req_fault;
                        if (!bus.req_write) begin
                            rdata_d = '0;
                        end
                    end else begin
                        state_d = LSU_ACCESS;
                    end
                end
            end
            LSU_ACCESS: begin
                if (bus.mem_ack) begin
                    state_d = LSU_RESP;
                    cause_d = FAULT_NONE;
                    if (!write_q) begin
                        rdata_d = align_load;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LSU_RESP;
                    cause_d = FAULT_TIMEOUT;
                    if (!write_q) begin
                        rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            cause_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            cause_q <= cause_d;
        end
    end

    // Request payload is only consumed in ACCESS, so it needs no reset.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        f3_q    <= f3_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign in_access       = (state_q == LSU_ACCESS);
    assign bus.mem_req     = in_access;
    assign bus.mem_we      = in_access & write_q;
    assign bus.mem_addr    = in_access ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_wdata   = in_access ? align_wdata : '0;
    assign bus.mem_be      = in_access ? align_be : '0;
    assign bus.busy        = (state_q != LSU_IDLE);
    assign bus.done        = (state_q == LSU_RESP);
    assign bus.rdata       = rdata_q;
    assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT_CYCLES = 4.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request from an idle cycle and returns at the done cycle.
    // ack_delay: index of the mem_req cycle that sees mem_ack (-1 = never).
    task automatic run_txn(input logic wr, input logic [2:0] f3, input addr_t a,
                           input data_t wd, input int ack_delay, input data_t rdat,
                           output logic [3:0] be, output data_t mwd, output logic mwe,
                           output addr_t maddr, output int req_cycles,
                           output logic got_done, output data_t rd,
                           output logic [1:0] cause, output int lat);
        be = '0; mwd = '0; mwe = 1'b0; maddr = '0; rd = '0; cause = '0;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.funct3 = f3;
        bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_write = ~wr; bus.funct3 = 3'b111;
        bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'hFFFF_FFFF;
        req_cycles = 0; got_done = 1'b0; lat = 1;
        for (int i = 0; i < 64 && !got_done; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                rd = bus.rdata;
                cause = bus.fault_cause;
            end else begin
                if (bus.mem_req) begin
                    if (req_cycles == 0) begin
                        be = bus.mem_be; mwd = bus.mem_wdata;
                        mwe = bus.mem_we; maddr = bus.mem_addr;
                    end
                    if (req_cycles == ack_delay) begin
                        bus.mem_ack = 1'b1; bus.mem_rdata = rdat;
                    end
                    req_cycles++;
                end
                @(posedge clk); #1;
                bus.mem_ack = 1'b0; bus.mem_rdata = 32'h5A5A_5A5A;
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.req_valid = 1'b1; bus.mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done got=%b%b exp=00", bus.busy, bus.done); end
        vectors++; if (bus.rdata !== 32'h0 || bus.fault_cause !== 2'b00) begin miscompares++; $display("FAIL reset_rdata_cause got=%h/%b exp=0/00", bus.rdata, bus.fault_cause); end
        vectors++; if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem got=%b%b%b %h %h exp=0", bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
        bus.req_valid = 1'b0; bus.mem_ack = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        logic [3:0] be; data_t mwd; logic mwe; addr_t maddr; int rc; logic gd; data_t rd; logic [1:0] c; int lat;
        run_txn(1'b0, LSU_F3__LW, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (be !== 4'b1111 || mwe !== 1'b0 || maddr !== 32'h100) begin miscompares++; $display("FAIL lw_bus got be=%b we=%b addr=%h exp 1111/0/100", be, mwe, maddr); end
        vectors++; if (gd !== 1'b1 || lat !== 4 || rc !== 3) begin miscompares++; $display("FAIL lw_timing got done=%b lat=%0d req=%0d exp 1/4/3", gd, lat, rc); end
        vectors++; if (rd !== 32'hDEAD_BEEF || c !== 2'b00) begin miscompares++; $display("FAIL lw_data got=%h/%b exp=deadbeef/00", rd, c); end
        @(posedge clk); #1;
        vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL lw_done_width got done=%b busy=%b exp 0/0", bus.done, bus.busy); end
    endtask

    task automatic test_byte_loads();
        logic [3:0] be; data_t mwd; logic mwe; addr_t maddr; int rc; logic gd; data_t rd; logic [1:0] c; int lat;
        run_txn(1'b0, LSU_F3__LB, 32'h103, 32'h0, 0, 32'h80FF_0000, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (be !== 4'b1000 || maddr !== 32'h100 || rd !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb got be=%b addr=%h rd=%h exp 1000/100/ffffff80", be, maddr, rd); end
        vectors++; if (lat !== 2 || gd !== 1'b1) begin miscompares++; $display("FAIL lb_latency got=%0d/%b exp=2/1", lat, gd); end
        @(posedge clk); #1;
        run_txn(1'b0, LSU_F3__LBU, 32'h103, 32'h0, 0, 32'h80FF_0000, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (be !== 4'b1000 || rd !== 32'h0000_0080 || c !== 2'b00) begin miscompares++; $display("FAIL lbu got be=%b rd=%h c=%b exp 1000/00000080/00", be, rd, c); end
        @(posedge clk); #1;
    endtask

    task automatic test_half_loads();
        logic [3:0] be; data_t mwd; logic mwe; addr_t maddr; int rc; logic gd; data_t rd; logic [1:0] c; int lat;
        run_txn(1'b0, LSU_F3__LH, 32'h102, 32'h0, 1, 32'h8001_0000, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (be !== 4'b1100 || rd !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh got be=%b rd=%h exp 1100/ffff8001", be, rd); end
        @(posedge clk); #1;
        run_txn(1'b0, LSU_F3__LH, 32'h100, 32'h0, 0, 32'hFFFF_7FFF, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (be !== 4'b0011 || rd !== 32'h0000_7FFF) begin miscompares++; $display("FAIL lh_pos got be=%b rd=%h exp 0011/00007fff", be, rd); end
        @(posedge clk); #1;
        run_txn(1'b0, LSU_F3__LHU, 32'h102, 32'h0, 0, 32'h8001_0000, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (rd !== 32'h0000_8001) begin miscompares++; $display("FAIL lhu got=%h exp=00008001", rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        logic [3:0] be; data_t mwd; logic mwe; addr_t maddr; int rc; logic gd; data_t rd; logic [1:0] c; int lat;
        run_txn(1'b1, LSU_F3__SH, 32'h202, 32'h1234_ABCD, 0, 32'h0, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (be !== 4'b1100 || mwd !== 32'hABCD_ABCD || mwe !== 1'b1 || maddr !== 32'h200) begin miscompares++; $display("FAIL sh_bus got be=%b wd=%h we=%b addr=%h exp 1100/abcdabcd/1/200", be, mwd, mwe, maddr); end
        vectors++; if (rd !== 32'h0000_8001 || c !== 2'b00 || gd !== 1'b1) begin miscompares++; $display("FAIL sh_rdata_kept got=%h/%b exp=00008001/00", rd, c); end
        @(posedge clk); #1;
        run_txn(1'b1, LSU_F3__SB, 32'h001, 32'h0000_00AB, 0, 32'h0, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (be !== 4'b0010 || mwd !== 32'hABAB_ABAB || maddr !== 32'h0) begin miscompares++; $display("FAIL sb got be=%b wd=%h addr=%h exp 0010/abababab/0", be, mwd, maddr); end
        @(posedge clk); #1;
        run_txn(1'b1, LSU_F3__SW, 32'h304, 32'h0102_0304, 0, 32'h0, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (be !== 4'b1111 || mwd !== 32'h0102_0304 || maddr !== 32'h304) begin miscompares++; $display("FAIL sw got be=%b wd=%h addr=%h exp 1111/01020304/304", be, mwd, maddr); end
        @(posedge clk); #1;
    endtask

    task automatic test_faults();
        logic [3:0] be; data_t mwd; logic mwe; addr_t maddr; int rc; logic gd; data_t rd; logic [1:0] c; int lat;
        run_txn(1'b1, LSU_F3__SW, 32'h102, 32'h0, 0, 32'h0, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (c !== 2'b01 || rc !== 0 || lat !== 1 || rd !== 32'h0000_8001) begin miscompares++; $display("FAIL sw_misalign got c=%b req=%0d lat=%0d rd=%h exp 01/0/1/00008001", c, rc, lat, rd); end
        @(posedge clk); #1;
        vectors++; if (bus.fault_cause !== 2'b01 || bus.done !== 1'b0) begin miscompares++; $display("FAIL cause_hold got=%b done=%b exp=01/0", bus.fault_cause, bus.done); end
        run_txn(1'b0, LSU_F3__LW, 32'h101, 32'h0, 0, 32'h0, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (c !== 2'b01 || rc !== 0 || lat !== 1 || rd !== 32'h0) begin miscompares++; $display("FAIL lw_misalign got c=%b req=%0d lat=%0d rd=%h exp 01/0/1/0", c, rc, lat, rd); end
        @(posedge clk); #1;
        run_txn(1'b0, 3'b011, 32'h101, 32'h0, 0, 32'h0, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (c !== 2'b10 || rc !== 0) begin miscompares++; $display("FAIL illegal_priority got c=%b req=%0d exp 10/0", c, rc); end
        @(posedge clk); #1;
        run_txn(1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (c !== 2'b10 || rc !== 0) begin miscompares++; $display("FAIL store_illegal got c=%b req=%0d exp 10/0", c, rc); end
        @(posedge clk); #1;
        run_txn(1'b0, LSU_F3__LW, 32'h104, 32'h0, 0, 32'h1122_3344, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (c !== 2'b00 || rd !== 32'h1122_3344) begin miscompares++; $display("FAIL cause_clear got c=%b rd=%h exp 00/11223344", c, rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        logic [3:0] be; data_t mwd; logic mwe; addr_t maddr; int rc; logic gd; data_t rd; logic [1:0] c; int lat;
        run_txn(1'b0, LSU_F3__LW, 32'h100, 32'h0, -1, 32'h0, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (rc !== 4 || gd !== 1'b1 || c !== 2'b11 || rd !== 32'h0) begin miscompares++; $display("FAIL timeout got req=%0d done=%b c=%b rd=%h exp 4/1/11/0", rc, gd, c, rd); end
        @(posedge clk); #1;
        run_txn(1'b0, LSU_F3__LW, 32'h100, 32'h0, 3, 32'hCAFE_F00D, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        vectors++; if (rc !== 4 || c !== 2'b00 || rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL ack_last got req=%0d c=%b rd=%h exp 4/00/cafef00d", rc, c, rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [3:0] be; data_t mwd; logic mwe; addr_t maddr; int rc; logic gd; data_t rd; logic [1:0] c; int lat;
        int dones;
        run_txn(1'b1, LSU_F3__SW, 32'h102, 32'h0, 0, 32'h0, be, mwd, mwe, maddr, rc, gd, rd, c, lat);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.funct3 = LSU_F3__LW; bus.addr = 32'h100;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL abort_in_access got mem_req=%b exp=1", bus.mem_req); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.busy, bus.done} !== 8'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL abort_outputs got req=%b be=%b busy=%b done=%b addr=%h exp 0", bus.mem_req, bus.mem_be, bus.busy, bus.done, bus.mem_addr); end
        vectors++; if (bus.rdata !== 32'h0 || bus.fault_cause !== 2'b00) begin miscompares++; $display("FAIL abort_result got rd=%h c=%b exp 0/00", bus.rdata, bus.fault_cause); end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ack = 1'b1;
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        bus.mem_ack = 1'b0;
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    endtask

    task automatic test_back_to_back();
        int    dones;
        data_t rd;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.funct3 = LSU_F3__LW; bus.addr = 32'h100;
        @(posedge clk); #1;
        bus.req_write = 1'b1; bus.funct3 = LSU_F3__SW; bus.addr = 32'h300; bus.wdata = 32'h7777_7777;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        vectors++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h100) begin miscompares++; $display("FAIL busy_ignore got req=%b we=%b addr=%h exp 1/0/100", bus.mem_req, bus.mem_we, bus.mem_addr); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
        dones = 0; rd = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            if (bus.done) begin dones++; rd = bus.rdata; end
        end
        vectors++; if (dones !== 1 || rd !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL single_done got dones=%0d rd=%h exp 1/0badf00d", dones, rd); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.funct3 = 3'b000;
        bus.addr = '0; bus.wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_lw();
        test_byte_loads();
        test_half_loads();
        test_store();
        test_faults();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
